// File: rtl/tank_pkg.sv
// Shared types and constants for the tank controller: direction encoding,
// USB HID keycodes for both players and tank start coordinates.
package tank_pkg;

    typedef enum logic [2:0] {
        DIR_UP    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_t;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    localparam logic [9:0] P1_START_X = 10'd100;
    localparam logic [9:0] P2_START_X = 10'd540;
    localparam logic [9:0] START_Y    = 10'd240;

endpackage

// File: rtl/tank_bullet_slot.sv
// One bullet slot: latches spawn position/direction, flies BULLET_STEP per
// frame tick, retires at the screen edge, and is cleared by a kill request.
module tank_bullet_slot
    import tank_pkg::*;
#(
    parameter int BULLET_STEP = 5,
    parameter int BUL_W       = 8,
    parameter int BUL_H       = 8,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       tick,
    input  logic       spawn,
    input  logic [9:0] spawn_x,
    input  logic [9:0] spawn_y,
    input  dir_t       spawn_dir,
    input  logic       kill,
    output logic       active,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y
);

    localparam logic signed [11:0] STEP_S = 12'(BULLET_STEP);
    localparam logic signed [11:0] X_LAST = 12'(X_MAX - BUL_W + 1);
    localparam logic signed [11:0] Y_LAST = 12'(Y_MAX - BUL_H + 1);

    dir_t                dir;
    logic signed [11:0]  nx;
    logic signed [11:0]  ny;
    logic                off_screen;

    always_comb begin
        nx = $signed({2'b00, pos_x});
        ny = $signed({2'b00, pos_y});
        case (dir)
            DIR_UP:    ny = ny - STEP_S;
            DIR_DOWN:  ny = ny + STEP_S;
            DIR_LEFT:  nx = nx - STEP_S;
            DIR_RIGHT: nx = nx + STEP_S;
            default:   ny = ny - STEP_S;
        endcase
        off_screen = (nx < 0) || (ny < 0) || (nx > X_LAST) || (ny > Y_LAST);
    end

    // Kill only drops the active flag; the last position is left in place.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            active <= 1'b0;
            pos_x  <= '0;
            pos_y  <= '0;
            dir    <= DIR_UP;
        end else if (kill) begin
            active <= 1'b0;
        end else if (spawn) begin
            active <= 1'b1;
            pos_x  <= spawn_x;
            pos_y  <= spawn_y;
            dir    <= spawn_dir;
        end else if (tick && active) begin
            if (off_screen) begin
                active <= 1'b0;
                pos_x  <= '0;
                pos_y  <= '0;
            end else begin
                pos_x <= nx[9:0];
                pos_y <= ny[9:0];
            end
        end
    end

endmodule

// File: rtl/tank_unit_multishot.sv
// Per-player tank controller with a pool of NUM_BULLETS bullets.
// Optional macro FIRE_COOLDOWN_EN adds a COOLDOWN_FRAMES shot cooldown.
module tank_unit_multishot
    import tank_pkg::*;
#(
    parameter int NUM_BULLETS     = 4,
    parameter int TANK_STEP       = 1,
    parameter int BULLET_STEP     = 5,
    parameter int TANK_W          = 32,
    parameter int TANK_H          = 32,
    parameter int BUL_W           = 8,
    parameter int BUL_H           = 8,
    parameter int X_MAX           = 639,
    parameter int Y_MAX           = 479,
    parameter int COOLDOWN_FRAMES = 15,
    localparam int IDX_W          = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_clk,
    input  logic                      player,
    input  logic [7:0]                keycode,
    input  logic                      can_move,
    input  logic [NUM_BULLETS-1:0]    bullet_kill,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    output logic [9:0]                tank_x,
    output logic [9:0]                tank_y,
    output logic [2:0]                tank_dir,
    output logic [NUM_BULLETS-1:0]    bullet_active,
    output logic [NUM_BULLETS*10-1:0] bullet_x,
    output logic [NUM_BULLETS*10-1:0] bullet_y,
    output logic                      is_tank,
    output logic                      is_bullet,
    output logic [IDX_W-1:0]          bullet_idx
);

    localparam logic [9:0] STEP10 = 10'(TANK_STEP);
    localparam logic [9:0] X_LIM  = 10'(X_MAX - TANK_W);
    localparam logic [9:0] Y_LIM  = 10'(Y_MAX - TANK_H);
    localparam logic signed [11:0] HX = 12'(TANK_W / 2 - BUL_W / 2);
    localparam logic signed [11:0] HY = 12'(TANK_H / 2 - BUL_H / 2);
    localparam logic signed [11:0] X_LAST = 12'(X_MAX - BUL_W + 1);
    localparam logic signed [11:0] Y_LAST = 12'(Y_MAX - BUL_H + 1);

    logic frame_s1, frame_s2, frame_prev, tick;
    logic [7:0] k_up, k_dn, k_lf, k_rt, k_fire;
    logic mv, fire_key, fire_prev, fire_ok, cool_ok, found, spawn_in;
    dir_t dir_q, mv_dir, dir_next;
    logic [9:0] x_next, y_next;
    logic signed [11:0] tx, ty, sx, sy;
    logic [NUM_BULLETS-1:0] alloc_oh, spawn_vec;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_s1   <= 1'b0;
            frame_s2   <= 1'b0;
            frame_prev <= 1'b0;
        end else begin
            frame_s1   <= frame_clk;
            frame_s2   <= frame_s1;
            frame_prev <= frame_s2;
        end
    end
    assign tick = frame_s2 & ~frame_prev;

    assign k_up   = player ? KEY_UP    : KEY_W;
    assign k_dn   = player ? KEY_DOWN  : KEY_S;
    assign k_lf   = player ? KEY_LEFT  : KEY_A;
    assign k_rt   = player ? KEY_RIGHT : KEY_D;
    assign k_fire = player ? KEY_ENTER : KEY_SPACE;
    assign fire_key = (keycode == k_fire);

    always_comb begin
        mv     = 1'b1;
        mv_dir = dir_q;
        if (keycode == k_up)      mv_dir = DIR_UP;
        else if (keycode == k_dn) mv_dir = DIR_DOWN;
        else if (keycode == k_lf) mv_dir = DIR_LEFT;
        else if (keycode == k_rt) mv_dir = DIR_RIGHT;
        else                      mv = 1'b0;
        dir_next = mv ? mv_dir : dir_q;
        x_next   = tank_x;
        y_next   = tank_y;
        // Steps saturate at the clamp limits rather than wrapping.
        if (mv && can_move) begin
            case (mv_dir)
                DIR_UP:    y_next = (tank_y < STEP10) ? 10'd0 : tank_y - STEP10;
                DIR_DOWN:  y_next = ({1'b0, tank_y} + {1'b0, STEP10} > {1'b0, Y_LIM}) ? Y_LIM : tank_y + STEP10;
                DIR_LEFT:  x_next = (tank_x < STEP10) ? 10'd0 : tank_x - STEP10;
                DIR_RIGHT: x_next = ({1'b0, tank_x} + {1'b0, STEP10} > {1'b0, X_LIM}) ? X_LIM : tank_x + STEP10;
                default:   y_next = tank_y;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            tank_x    <= player ? P2_START_X : P1_START_X;
            tank_y    <= START_Y;
            dir_q     <= DIR_UP;
            fire_prev <= 1'b0;
        end else if (tick) begin
            tank_x    <= x_next;
            tank_y    <= y_next;
            dir_q     <= dir_next;
            fire_prev <= fire_key;
        end
    end
    assign tank_dir = dir_q;

    always_comb begin
        tx = $signed({2'b00, tank_x});
        ty = $signed({2'b00, tank_y});
        case (dir_next)
            DIR_DOWN:  begin sx = tx + HX;              sy = ty + 12'(TANK_H); end
            DIR_LEFT:  begin sx = tx - 12'(BUL_W);      sy = ty + HY;          end
            DIR_RIGHT: begin sx = tx + 12'(TANK_W);     sy = ty + HY;          end
            default:   begin sx = tx + HX;              sy = ty - 12'(BUL_H);  end
        endcase
        spawn_in = (sx >= 0) && (sy >= 0) && (sx <= X_LAST) && (sy <= Y_LAST);
    end

    // Lowest-index slot that is idle and not being killed this cycle.
    always_comb begin
        alloc_oh = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!found && !bullet_active[i] && !bullet_kill[i]) begin
                alloc_oh[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign fire_ok   = tick & fire_key & ~fire_prev & cool_ok & found & spawn_in;
    assign spawn_vec = fire_ok ? alloc_oh : '0;

`ifdef FIRE_COOLDOWN_EN
    logic [7:0] cooldown;
    assign cool_ok = (cooldown == 8'd0);
    always_ff @(posedge Clk) begin
        if (Reset)
            cooldown <= 8'd0;
        else if (tick) begin
            if (fire_ok)
                cooldown <= 8'(COOLDOWN_FRAMES);
            else if (cooldown != 8'd0)
                cooldown <= cooldown - 8'd1;
        end
    end
`else
    assign cool_ok = 1'b1;
`endif

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        tank_bullet_slot #(
            .BULLET_STEP(BULLET_STEP),
            .BUL_W      (BUL_W),
            .BUL_H      (BUL_H),
            .X_MAX      (X_MAX),
            .Y_MAX      (Y_MAX)
        ) u_slot (
            .Clk      (Clk),
            .Reset    (Reset),
            .tick     (tick),
            .spawn    (spawn_vec[g]),
            .spawn_x  (sx[9:0]),
            .spawn_y  (sy[9:0]),
            .spawn_dir(dir_next),
            .kill     (bullet_kill[g]),
            .active   (bullet_active[g]),
            .pos_x    (bullet_x[10*g +: 10]),
            .pos_y    (bullet_y[10*g +: 10])
        );
    end

    always_comb begin
        logic [10:0] px, py, bx, by;
        logic        hit;
        px = {1'b0, DrawX};
        py = {1'b0, DrawY};
        is_tank = (px >= {1'b0, tank_x}) && (px < {1'b0, tank_x} + 11'(TANK_W)) &&
                  (py >= {1'b0, tank_y}) && (py < {1'b0, tank_y} + 11'(TANK_H));
        is_bullet  = 1'b0;
        bullet_idx = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            bx  = {1'b0, bullet_x[10*i +: 10]};
            by  = {1'b0, bullet_y[10*i +: 10]};
            hit = bullet_active[i] && (px >= bx) && (px < bx + 11'(BUL_W)) &&
                  (py >= by) && (py < by + 11'(BUL_H));
            if (hit && !is_bullet) begin
                is_bullet  = 1'b1;
                bullet_idx = IDX_W'(i);
            end
        end
    end

endmodule
